morse_text_line_ctrl: RTL and testbench
=======================================

Name: morse_text_line_ctrl

Overview:
- Controller and sequencer for the on-screen text line of the Morse decoder.
- Accepts decoded letter and edit commands through a valid/ready handshake and holds them in a DEPTH-cell character buffer.
- Applies updates only while the VGA generator reports vertical blanking, so a frame never tears. Handles cursor advance, backspace, clear and full-line scroll-left.
- The pixel renderer reads the buffer through a registered read port during the active display area.

Parameters:
DEPTH, 16, number of character cells on the line (power of two, at least 2)
IDXW, 4, log2(DEPTH), width of a cell index

Ports:
board_clk  in  1  system clock
reset  in  1  asynchronous, active-high
cmd_valid  in  1  command strobe from the decoder
cmd_code  in  5  0-25 = A-Z, 26 = space, 27 = backspace, 28 = clear, 29-31 = no-op
cmd_ready  out  1  block can accept a command
vblank  in  1  level, high while the VGA generator is in vertical blanking
rd_index  in  IDXW  cell index requested by the renderer
rd_code  out  5  registered cell contents; 31 = blank cell
cursor  out  IDXW+1  number of occupied cells, 0..DEPTH
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, any time including mid-operation):
  - all cells = 31, cursor = 0, rd_code = 31, state = IDLE, scroll/clear counter = 0, latched command = 0.
  - cmd_ready = 1, busy = 0.
  - Any operation in progress is abandoned.
- States: IDLE, WAIT_VB, WRITE, BKSP, SCROLL, CLEAR.
- Outputs decoded from state: cmd_ready = (state == IDLE); busy = not cmd_ready.
- IDLE:
  - Handshake fires on an edge with cmd_valid & cmd_ready. The block latches cmd_code.
  - Codes 29-31 are accepted and dropped; state stays IDLE.
  - Any other code moves the state to WAIT_VB.
  - cmd_valid while busy is ignored. The command is not latched and the requester must hold it.
- WAIT_VB: holds until an edge samples vblank = 1, then dispatches on the latched code:
  - Letter or space with cursor < DEPTH: go to WRITE.
  - Letter or space with cursor == DEPTH: go to SCROLL with counter = 0.
  - Backspace: go to BKSP.
  - Clear: go to CLEAR with counter = 0.
- WRITE: one edge. cell[cursor] = code, cursor + 1, then IDLE.
- BKSP: one edge.
  - If cursor > 0: cell[cursor-1] = 31 and cursor - 1.
  - If cursor == 0: no change.
  - Then IDLE.
- SCROLL: exactly DEPTH edges.
  - Edges with counter 0..DEPTH-2: cell[counter] = cell[counter+1], counter + 1.
  - Final edge: cell[DEPTH-1] = code, then IDLE.
  - cursor stays at DEPTH.
- CLEAR: exactly DEPTH edges.
  - Each edge: cell[counter] = 31, counter + 1.
  - Final edge also sets cursor = 0, then IDLE.
- An operation that has started runs to completion even if vblank drops. No vblank check occurs after dispatch.
- Latency: a letter accepted at edge E0, with vblank high at E1, is written at edge E2. cmd_ready is 1 after E2. The minimum command-to-command spacing is 3 edges.
- Read port:
  - Every edge: rd_code <= cell[rd_index]. Read latency is 1 cycle and reads are never stalled.
  - A read and a write to the same cell on the same edge returns the old value.
- cursor arithmetic is unsigned IDXW+1 bits. It never exceeds DEPTH and never goes below 0. There is no wrap.

Test Plan:
- Reset, then read every index -> rd_code = 31 for all 16 cells, cursor = 0, cmd_ready = 1, busy = 0.
- vblank held 0, send code 7 (H) -> cmd_ready drops and cell 0 stays 31. Raise vblank -> 2 edges later cell 0 = 7, cursor = 1, cmd_ready = 1.
- vblank = 1, send codes 0..15 then 16 -> cells hold 1..16, cursor = 16, busy high for exactly 17 edges during the scroll.
- Three letters, then backspace, then backspace on an empty line (after clear) -> first backspace gives cursor 2 and cell 2 = 31; backspace at cursor 0 leaves state unchanged.
- Fill 5 cells, send code 28 -> busy for 17 edges total (1 WAIT_VB + 16 CLEAR), then all cells = 31, cursor = 0. Code 30 is accepted with no change and cmd_ready never drops.
- Assert reset in the middle of a SCROLL (counter = 7) -> all outputs return to reset values immediately and the next letter is written to cell 0.

Source files
------------

// File: rtl/morse_text_line_ctrl.sv
// Text-line controller for the Morse decoder display: buffers decoded characters and
// applies writes, backspace, clear and scroll only during vertical blanking.
module morse_text_line_ctrl #(
    parameter int DEPTH = 16,
    parameter int IDXW  = 4
) (
    input  logic            board_clk,
    input  logic            reset,
    input  logic            cmd_valid,
    input  logic [4:0]      cmd_code,
    output logic            cmd_ready,
    input  logic            vblank,
    input  logic [IDXW-1:0] rd_index,
    output logic [4:0]      rd_code,
    output logic [IDXW:0]   cursor,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VB,
        S_WRITE,
        S_BKSP,
        S_SCROLL,
        S_CLEAR
    } state_e;

    localparam logic [4:0]      CODE_SPACE = 5'd26;
    localparam logic [4:0]      CODE_BKSP  = 5'd27;
    localparam logic [4:0]      CODE_CLEAR = 5'd28;
    localparam logic [4:0]      CODE_BLANK = 5'd31;
    localparam logic [IDXW:0]   CUR_FULL   = (IDXW+1)'(DEPTH);
    localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(DEPTH-1);

    state_e          state_q, state_d;
    logic [4:0]      cells_q [DEPTH];
    logic [IDXW:0]   cursor_q, cursor_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic [IDXW-1:0] cnt_inc;
    logic [4:0]      code_q, code_d;
    logic [4:0]      rd_code_q;

    logic            wr_en;
    logic [IDXW-1:0] wr_addr;
    logic [4:0]      wr_data;

    assign cnt_inc = cnt_q + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_code <= CODE_CLEAR) begin
                    state_d = S_WAIT_VB;
                end
            end
            S_WAIT_VB: begin
                if (vblank) begin
                    if (code_q <= CODE_SPACE) begin
                        state_d = (cursor_q == CUR_FULL) ? S_SCROLL : S_WRITE;
                    end else if (code_q == CODE_BKSP) begin
                        state_d = S_BKSP;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_WRITE, S_BKSP: state_d = S_IDLE;
            S_SCROLL, S_CLEAR: begin
                if (cnt_q == IDX_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
    end

    // Single write port: each state touches at most one cell per edge.
    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = CODE_BLANK;
        cursor_d = cursor_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    code_d = cmd_code;
                end
            end
            S_WAIT_VB: begin
                if (vblank) begin
                    cnt_d = '0;
                end
            end
            S_WRITE: begin
                wr_en    = 1'b1;
                wr_addr  = cursor_q[IDXW-1:0];
                wr_data  = code_q;
                cursor_d = cursor_q + 1'b1;
            end
            S_BKSP: begin
                if (cursor_q != '0) begin
                    wr_en    = 1'b1;
                    wr_addr  = cursor_q[IDXW-1:0] - 1'b1;
                    cursor_d = cursor_q - 1'b1;
                end
            end
            S_SCROLL: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_data = (cnt_q == IDX_LAST) ? code_q : cells_q[cnt_inc];
                cnt_d   = cnt_inc;
            end
            S_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                cnt_d   = cnt_inc;
                if (cnt_q == IDX_LAST) begin
                    cursor_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            // NOTE: the cell array is reset (so it maps to flops, not RAM) because the renderer must show a blank line straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                cells_q[i] <= CODE_BLANK;
            end
            cursor_q  <= '0;
            cnt_q     <= '0;
            code_q    <= '0;
            rd_code_q <= CODE_BLANK;
        end else begin
            if (wr_en) begin
                cells_q[wr_addr] <= wr_data;
            end
            cursor_q  <= cursor_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            rd_code_q <= cells_q[rd_index];
        end
    end

    assign rd_code = rd_code_q;
    assign cursor  = cursor_q;

endmodule

// File: tb/tb_morse_text_line_ctrl.sv
// Self-checking bench for morse_text_line_ctrl: directed scenarios plus randomized
// command streams checked against a queue-based model of the text line.
module tb_morse_text_line_ctrl;

    localparam int DEPTH = 16;
    localparam int IDXW  = 4;

    logic            board_clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic [4:0]      cmd_code;
    logic            cmd_ready;
    logic            vblank;
    logic [IDXW-1:0] rd_index;
    logic [4:0]      rd_code;
    logic [IDXW:0]   cursor;
    logic            busy;

    int checks = 0;
    int errors = 0;

    // Model: the occupied part of the line, oldest character first.
    int line_q[$];

    always #5 board_clk = ~board_clk;

    morse_text_line_ctrl #(.DEPTH(DEPTH), .IDXW(IDXW)) dut (
        .board_clk (board_clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_ready (cmd_ready),
        .vblank    (vblank),
        .rd_index  (rd_index),
        .rd_code   (rd_code),
        .cursor    (cursor),
        .busy      (busy)
    );

    function automatic logic [4:0] exp_cell(input int i);
        if (i < line_q.size()) return 5'(line_q[i]);
        return 5'd31;
    endfunction

    function automatic logic [IDXW:0] exp_cursor();
        return (IDXW+1)'(line_q.size());
    endfunction

    function automatic void model_apply(input int code);
        if (code <= 26) begin
            if (line_q.size() == DEPTH) void'(line_q.pop_front());
            line_q.push_back(code);
        end else if (code == 27) begin
            if (line_q.size() > 0) void'(line_q.pop_back());
        end else if (code == 28) begin
            line_q.delete();
        end
    endfunction

    task automatic tick();
        @(posedge board_clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        cmd_code  = '0;
        rd_index  = '0;
        vblank    = 1'b0;
        @(negedge board_clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        line_q.delete();
        tick();
    endtask

    task automatic wait_idle(input bit rand_vb, output int n);
        n = 0;
        while (!cmd_ready && n < 200) begin
            if (rand_vb) vblank = ($urandom_range(0, 2) == 0);
            tick();
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
        end
    endtask

    task automatic send(input logic [4:0] code, input bit rand_vb);
        int n;
        wait_idle(rand_vb, n);
        cmd_code  = code;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        model_apply(int'(code));
    endtask

    task automatic read_cell(input int idx, output logic [4:0] v);
        rd_index = IDXW'(idx);
        tick();
        v = rd_code;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [4:0] v;
        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_code = '0;
        vblank = 1'b0;
        rd_index = '0;
        #1 reset = 1'b1;
        #1;
        checks++; if (cursor !== 5'd0) begin errors++; $display("FAIL reset_cursor: got %0d, expected 0", cursor); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b, expected 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
        checks++; if (rd_code !== 5'd31) begin errors++; $display("FAIL reset_rd_code: got %0d, expected 31", rd_code); end
        reset = 1'b0;
        line_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            read_cell(i, v);
            checks++;
            if (v !== 5'd31) begin errors++; $display("FAIL reset_cell[%0d]: got %0d, expected 31", i, v); end
        end
    endtask

    task automatic test_vblank_gate();
        do_reset();
        vblank = 1'b0;
        rd_index = '0;
        send(5'd7, 1'b0);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL gate_ready_drop: got %0b, expected 0", cmd_ready); end
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gate_busy_hold: got %0b, expected 1", busy); end
        checks++; if (rd_code !== 5'd31) begin errors++; $display("FAIL gate_cell0_held: got %0d, expected 31", rd_code); end
        vblank = 1'b1;
        tick();
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL gate_dispatch_ready: got %0b, expected 0", cmd_ready); end
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL gate_write_ready: got %0b, expected 1", cmd_ready); end
        checks++; if (cursor !== exp_cursor()) begin errors++; $display("FAIL gate_cursor: got %0d, expected %0d", cursor, exp_cursor()); end
        checks++; if (rd_code !== 5'd31) begin errors++; $display("FAIL gate_read_old: got %0d, expected 31", rd_code); end
        tick();
        checks++; if (rd_code !== exp_cell(0)) begin errors++; $display("FAIL gate_cell0: got %0d, expected %0d", rd_code, exp_cell(0)); end
    endtask

    task automatic test_scroll();
        int n;
        logic [4:0] v;
        do_reset();
        vblank = 1'b1;
        for (int i = 0; i < DEPTH; i++) send(5'(i), 1'b0);
        wait_idle(1'b0, n);
        checks++; if (cursor !== 5'd16) begin errors++; $display("FAIL scroll_full_cursor: got %0d, expected 16", cursor); end
        send(5'd16, 1'b0);
        count_busy(n);
        checks++; if (n != 17) begin errors++; $display("FAIL scroll_busy_len: got %0d, expected 17", n); end
        checks++; if (cursor !== exp_cursor()) begin errors++; $display("FAIL scroll_cursor: got %0d, expected %0d", cursor, exp_cursor()); end
        for (int i = 0; i < DEPTH; i++) begin
            read_cell(i, v);
            checks++;
            if (v !== exp_cell(i)) begin errors++; $display("FAIL scroll_cell[%0d]: got %0d, expected %0d", i, v, exp_cell(i)); end
        end
    endtask

    task automatic test_backspace();
        int n;
        logic [4:0] v;
        do_reset();
        vblank = 1'b1;
        repeat (3) send(5'($urandom_range(0, 26)), 1'b0);
        send(5'd27, 1'b0);
        wait_idle(1'b0, n);
        checks++; if (cursor !== 5'd2) begin errors++; $display("FAIL bksp_cursor: got %0d, expected 2", cursor); end
        for (int i = 0; i < 4; i++) begin
            read_cell(i, v);
            checks++;
            if (v !== exp_cell(i)) begin errors++; $display("FAIL bksp_cell[%0d]: got %0d, expected %0d", i, v, exp_cell(i)); end
        end
        send(5'd28, 1'b0);
        wait_idle(1'b0, n);
        send(5'd27, 1'b0);
        count_busy(n);
        checks++; if (n != 2) begin errors++; $display("FAIL bksp_empty_busy_len: got %0d, expected 2", n); end
        checks++; if (cursor !== 5'd0) begin errors++; $display("FAIL bksp_empty_cursor: got %0d, expected 0", cursor); end
        for (int i = 0; i < DEPTH; i++) begin
            read_cell(i, v);
            checks++;
            if (v !== exp_cell(i)) begin errors++; $display("FAIL bksp_empty_cell[%0d]: got %0d, expected %0d", i, v, exp_cell(i)); end
        end
    endtask

    task automatic test_clear();
        int n;
        bit dropped;
        logic [4:0] v;
        do_reset();
        vblank = 1'b1;
        repeat (5) send(5'($urandom_range(0, 26)), 1'b0);
        send(5'd28, 1'b0);
        count_busy(n);
        checks++; if (n != 17) begin errors++; $display("FAIL clear_busy_len: got %0d, expected 17", n); end
        checks++; if (cursor !== 5'd0) begin errors++; $display("FAIL clear_cursor: got %0d, expected 0", cursor); end
        for (int i = 0; i < DEPTH; i++) begin
            read_cell(i, v);
            checks++;
            if (v !== 5'd31) begin errors++; $display("FAIL clear_cell[%0d]: got %0d, expected 31", i, v); end
        end
        send(5'd30, 1'b0);
        dropped = !cmd_ready;
        repeat (3) begin
            tick();
            if (!cmd_ready) dropped = 1'b1;
        end
        checks++; if (dropped) begin errors++; $display("FAIL noop_ready: got ready drop, expected ready held at 1"); end
        checks++; if (cursor !== exp_cursor()) begin errors++; $display("FAIL noop_cursor: got %0d, expected %0d", cursor, exp_cursor()); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] v;
        do_reset();
        vblank = 1'b1;
        cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cmd_code = 5'($urandom_range(0, 26));
            model_apply(int'(cmd_code));
            tick();
            cmd_code = 5'd29;
            checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept[%0d]: got ready %0b, expected 0", k, cmd_ready); end
            tick();
            checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_dispatch[%0d]: got ready %0b, expected 0", k, cmd_ready); end
            tick();
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d]: got ready %0b, expected 1", k, cmd_ready); end
        end
        cmd_valid = 1'b0;
        checks++; if (cursor !== exp_cursor()) begin errors++; $display("FAIL b2b_cursor: got %0d, expected %0d", cursor, exp_cursor()); end
        for (int i = 0; i < 5; i++) begin
            read_cell(i, v);
            checks++;
            if (v !== exp_cell(i)) begin errors++; $display("FAIL b2b_cell[%0d]: got %0d, expected %0d", i, v, exp_cell(i)); end
        end
    endtask

    task automatic test_reset_mid_scroll();
        int n;
        logic [4:0] v;
        do_reset();
        vblank = 1'b1;
        for (int i = 0; i < DEPTH; i++) send(5'($urandom_range(0, 26)), 1'b0);
        send(5'd20, 1'b0);
        repeat (8) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midscroll_busy: got %0b, expected 1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (cursor !== 5'd0) begin errors++; $display("FAIL midscroll_reset_cursor: got %0d, expected 0", cursor); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midscroll_reset_ready: got %0b, expected 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midscroll_reset_busy: got %0b, expected 0", busy); end
        checks++; if (rd_code !== 5'd31) begin errors++; $display("FAIL midscroll_reset_rd_code: got %0d, expected 31", rd_code); end
        #1 reset = 1'b0;
        line_q.delete();
        tick();
        send(5'd9, 1'b0);
        wait_idle(1'b0, n);
        checks++; if (cursor !== 5'd1) begin errors++; $display("FAIL midscroll_next_cursor: got %0d, expected 1", cursor); end
        for (int i = 0; i < DEPTH; i++) begin
            read_cell(i, v);
            checks++;
            if (v !== exp_cell(i)) begin errors++; $display("FAIL midscroll_cell[%0d]: got %0d, expected %0d", i, v, exp_cell(i)); end
        end
    endtask

    task automatic test_random();
        int n;
        int idx;
        logic [4:0] v;
        do_reset();
        for (int k = 0; k < 80; k++) begin
            send(5'($urandom_range(0, 31)), 1'b1);
            wait_idle(1'b1, n);
            vblank = 1'b0;
            checks++; if (cursor !== exp_cursor()) begin errors++; $display("FAIL rand_cursor[%0d]: got %0d, expected %0d", k, cursor, exp_cursor()); end
            idx = $urandom_range(0, DEPTH - 1);
            read_cell(idx, v);
            checks++; if (v !== exp_cell(idx)) begin errors++; $display("FAIL rand_cell[%0d][%0d]: got %0d, expected %0d", k, idx, v, exp_cell(idx)); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            read_cell(i, v);
            checks++;
            if (v !== exp_cell(i)) begin errors++; $display("FAIL rand_final_cell[%0d]: got %0d, expected %0d", i, v, exp_cell(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_vblank_gate();
        test_scroll();
        test_backspace();
        test_clear();
        test_back_to_back();
        test_reset_mid_scroll();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
